// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - four-tap direct-form FIR with arithmetic scaling, saturation and registered output
module fir_filter #(
    parameter int NB_DATA  = 8,
    parameter int NB_COEFF = 8,
    parameter int COEFF0   = 1,
    parameter int COEFF1   = 2,
    parameter int COEFF2   = 2,
    parameter int COEFF3   = 1,
    parameter int NB_SHIFT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic signed [NB_DATA-1:0] i_data,
    output logic signed [NB_DATA-1:0] o_data
);

    // Four full-precision products of NB_DATA+NB_COEFF bits plus two guard bits
    // for the three additions, so the sum can never wrap.
    localparam int NB_ACC = NB_DATA + NB_COEFF + 2;
    localparam int NB_EXT_D = NB_ACC - NB_DATA;
    localparam int NB_EXT_C = NB_ACC - NB_COEFF;

    // Coefficients narrowed to their declared width, then sign-extended to the
    // accumulator width so every multiply and add is done at full precision.
    localparam logic signed [NB_COEFF-1:0] C0 = NB_COEFF'(COEFF0);
    localparam logic signed [NB_COEFF-1:0] C1 = NB_COEFF'(COEFF1);
    localparam logic signed [NB_COEFF-1:0] C2 = NB_COEFF'(COEFF2);
    localparam logic signed [NB_COEFF-1:0] C3 = NB_COEFF'(COEFF3);

    localparam logic signed [NB_ACC-1:0] C0_EXT = {{NB_EXT_C{C0[NB_COEFF-1]}}, C0};
    localparam logic signed [NB_ACC-1:0] C1_EXT = {{NB_EXT_C{C1[NB_COEFF-1]}}, C1};
    localparam logic signed [NB_ACC-1:0] C2_EXT = {{NB_EXT_C{C2[NB_COEFF-1]}}, C2};
    localparam logic signed [NB_ACC-1:0] C3_EXT = {{NB_EXT_C{C3[NB_COEFF-1]}}, C3};

    // Output clamp limits expressed at accumulator width for a signed compare.
    localparam logic signed [NB_ACC-1:0] SAT_MAX = NB_ACC'((1 << (NB_DATA - 1)) - 1);
    localparam logic signed [NB_ACC-1:0] SAT_MIN = NB_ACC'(-(1 << (NB_DATA - 1)));

    logic signed [NB_DATA-1:0] r_d1;
    logic signed [NB_DATA-1:0] r_d2;
    logic signed [NB_DATA-1:0] r_d3;
    logic signed [NB_DATA-1:0] r_data;

    logic signed [NB_ACC-1:0]  w_x0;
    logic signed [NB_ACC-1:0]  w_x1;
    logic signed [NB_ACC-1:0]  w_x2;
    logic signed [NB_ACC-1:0]  w_x3;
    logic signed [NB_ACC-1:0]  w_acc;
    logic signed [NB_ACC-1:0]  w_scaled;
    logic signed [NB_DATA-1:0] w_sat;

    assign w_x0 = {{NB_EXT_D{i_data[NB_DATA-1]}}, i_data};
    assign w_x1 = {{NB_EXT_D{r_d1[NB_DATA-1]}}, r_d1};
    assign w_x2 = {{NB_EXT_D{r_d2[NB_DATA-1]}}, r_d2};
    assign w_x3 = {{NB_EXT_D{r_d3[NB_DATA-1]}}, r_d3};

    assign w_acc = (w_x0 * C0_EXT) + (w_x1 * C1_EXT) + (w_x2 * C2_EXT) + (w_x3 * C3_EXT);

    // Arithmetic shift: truncates toward minus infinity, no rounding.
    assign w_scaled = w_acc >>> NB_SHIFT;

    // Clamp the scaled sum into the output sample range.
    always_comb begin
        w_sat = w_scaled[NB_DATA-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[NB_DATA-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[NB_DATA-1:0];
        end
    end

    // Delay line and output register; reset discards all history immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
            r_data <= '0;
        end else begin
            r_d1   <= i_data;
            r_d2   <= r_d1;
            r_d3   <= r_d2;
            r_data <= w_sat;
        end
    end

    assign o_data = r_data;

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - directed and model-checked bench for fir_filter
module tb_fir_filter;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic signed [7:0] i_data;
    logic signed [7:0] o_data;

    int n_checks = 0;
    int n_errors = 0;
    int hist [4];
    int m_exp;

    int step_exp  [5] = '{0, 1, 2, 3, 3};
    int imp_in    [6] = '{2, 0, 0, 0, 0, 0};
    int imp_exp   [6] = '{1, 2, 2, 1, 0, 0};
    int neg_in    [5] = '{-1, 0, 0, 0, 0};
    int neg_exp   [5] = '{-1, -1, -1, -1, 0};
    int sat_in    [8] = '{127, 127, 127, 127, -128, -128, -128, -128};
    int sat_exp   [8] = '{63, 127, 127, 127, 127, -2, -128, -128};

    fir_filter u_dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_data (o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_value(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: default taps 1,2,2,1, shift 1, clamp to 8-bit signed.
    function automatic int model_step(input int x);
        int s;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = x;
        s = hist[0] + 2 * hist[1] + 2 * hist[2] + hist[3];
        s = s >>> 1;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic clock_in(input int v);
        i_data = 8'(v);
        @(posedge i_clk);
        #1;
        m_exp = model_step(v);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        #1;
        check_value("async_reset", o_data, 0);
        for (int k = 0; k < 4; k++) hist[k] = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    initial begin
        logic signed [7:0] b;
        i_rst  = 1'b0;
        i_data = 8'sd5;
        for (int k = 0; k < 4; k++) hist[k] = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            check_value("reset_hold", o_data, 0);
        end
        i_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clock_in(1);
            check_value("step", o_data, step_exp[i]);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            clock_in(imp_in[i]);
            check_value("impulse", o_data, imp_exp[i]);
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            clock_in(neg_in[i]);
            check_value("neg_trunc", o_data, neg_exp[i]);
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            clock_in(sat_in[i]);
            check_value("saturate", o_data, sat_exp[i]);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            clock_in((i % 2 == 0) ? 1 : 2);
            check_value("alt_model", o_data, m_exp);
            if (i >= 3) check_value("alt_fill", o_data, 4);
        end

        do_reset();
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            clock_in(int'(b));
            check_value("random", o_data, m_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
